// File: rtl/eq_band_mixer.sv
// Five-band EQ recombination: weights each band by a double-buffered
// Q3.12 gain on one shared multiplier, then rounds and saturates to 16 bits.
// Ports: clk, rst_n, band_valid, band0..4_in, gain_we/addr/wdata,
//        y_out, y_valid, busy, overrun.
module eq_band_mixer #(
  parameter int N_BAND    = 5,
  parameter int GAIN_FRAC = 12,
  parameter int ACC_W     = 35
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        band_valid,
  input  logic [15:0] band0_in,
  input  logic [15:0] band1_in,
  input  logic [15:0] band2_in,
  input  logic [15:0] band3_in,
  input  logic [15:0] band4_in,
  input  logic        gain_we,
  input  logic [2:0]  gain_addr,
  input  logic [15:0] gain_wdata,
  output logic [15:0] y_out,
  output logic        y_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'(1) << (GAIN_FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(32768);
  localparam logic [15:0] UNITY = 16'(1) << GAIN_FRAC;

  state_t state, state_nx;

  logic [2:0]               idx;
  logic                     last;
  logic signed [15:0]       band_in [N_BAND];
  logic signed [15:0]       band_q  [N_BAND];
  logic signed [15:0]       shadow  [N_BAND];
  logic signed [15:0]       active  [N_BAND];
  logic signed [15:0]       b_sel;
  logic signed [15:0]       g_sel;
  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  prod_x;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shr;
  logic signed [15:0]       sat;

  assign band_in[0] = band0_in;
  assign band_in[1] = band1_in;
  assign band_in[2] = band2_in;
  assign band_in[3] = band3_in;
  assign band_in[4] = band4_in;

  always_comb begin
    b_sel = '0;
    g_sel = '0;
    for (int i = 0; i < N_BAND; i++) begin
      if (idx == 3'(i)) begin
        b_sel = band_q[i];
        g_sel = active[i];
      end
    end
  end

  assign prod   = b_sel * g_sel;
  assign prod_x = $signed({{(ACC_W-32){prod[31]}}, prod});
  assign last   = (idx == 3'(N_BAND - 1));

  // Round half up, then arithmetic shift back to sample scale.
  assign rnd = acc + HALF;
  assign shr = rnd >>> GAIN_FRAC;

  always_comb begin
    if (shr > MAXV)      sat = 16'sh7fff;
    else if (shr < MINV) sat = 16'sh8000;
    else                 sat = shr[15:0];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (band_valid) state_nx = MAC;
      MAC:     if (last)       state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      acc     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < N_BAND; i++) begin
        band_q[i] <= '0;
        shadow[i] <= UNITY;
        active[i] <= UNITY;
      end
    end else begin
      y_valid <= 1'b0;
      for (int i = 0; i < N_BAND; i++) begin
        if (gain_we && gain_addr == 3'(i))
          shadow[i] <= gain_wdata;
      end
      if (state != IDLE && band_valid)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (band_valid) begin
            acc <= '0;
            idx <= '0;
            for (int i = 0; i < N_BAND; i++) begin
              band_q[i] <= band_in[i];
              // Same-edge write goes straight into the new frame.
              if (gain_we && gain_addr == 3'(i))
                active[i] <= gain_wdata;
              else
                active[i] <= shadow[i];
            end
          end
        end
        MAC: begin
          acc <= acc + prod_x;
          idx <= idx + 3'd1;
        end
        OUT: begin
          y_out   <= sat;
          y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed and randomized checks of eq_band_mixer against an
// arithmetic mixing model with a shadow gain table.
module tb_eq_band_mixer;

  logic        clk = 0;
  logic        rst_n;
  logic        band_valid;
  logic [15:0] band0_in, band1_in, band2_in, band3_in, band4_in;
  logic        gain_we;
  logic [2:0]  gain_addr;
  logic [15:0] gain_wdata;
  logic [15:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  logic signed [15:0] bnd [5];
  logic signed [15:0] gm  [5];
  logic signed [31:0] exp_y;

  always #5 clk = ~clk;

  eq_band_mixer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .band_valid (band_valid),
    .band0_in   (band0_in),
    .band1_in   (band1_in),
    .band2_in   (band2_in),
    .band3_in   (band3_in),
    .band4_in   (band4_in),
    .gain_we    (gain_we),
    .gain_addr  (gain_addr),
    .gain_wdata (gain_wdata),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] mix_model();
    longint s = 0;
    for (int i = 0; i < 5; i++)
      s += longint'(bnd[i]) * longint'(gm[i]);
    s = (s + 2048) >>> 12;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 32'(s);
  endfunction

  task automatic set_bands(input int a, b, c, d, e);
    bnd[0] = 16'(a); bnd[1] = 16'(b); bnd[2] = 16'(c);
    bnd[3] = 16'(d); bnd[4] = 16'(e);
  endtask

  task automatic unity();
    for (int i = 0; i < 5; i++) gm[i] = 16'h1000;
  endtask

  // Called at a negedge; takes one cycle.
  task automatic write_gain(input logic [2:0] a, input logic [15:0] d);
    gain_we = 1; gain_addr = a; gain_wdata = d;
    if (a < 5) gm[a] = d;
    @(negedge clk);
    gain_we = 0;
  endtask

  // Presents bnd[] with band_valid (optionally with a same-edge gain
  // write) and captures the expected result from the model.
  task automatic start_frame(input logic we, input logic [2:0] a,
                             input logic [15:0] d);
    band0_in = bnd[0]; band1_in = bnd[1]; band2_in = bnd[2];
    band3_in = bnd[3]; band4_in = bnd[4];
    band_valid = 1;
    gain_we = we; gain_addr = a; gain_wdata = d;
    if (we && a < 5) gm[a] = d;
    exp_y = mix_model();
    @(negedge clk);
    band_valid = 0;
    gain_we = 0;
  endtask

  task automatic wait_out(input string tag, input int n0,
                          input int lat_exp, input int busy_exp);
    int n = n0;
    int bc = busy ? 1 : 0;
    while (!y_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (!y_valid && busy) bc++;
    end
    chk({tag, "_seen"}, 32'(y_valid), 1);
    chk({tag, "_y"}, $signed(y_out), exp_y);
    if (lat_exp >= 0) chk({tag, "_lat"}, n, lat_exp);
    if (busy_exp >= 0) chk({tag, "_busy"}, bc, busy_exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(y_valid), 0);
    chk({tag, "_hold"}, $signed(y_out), exp_y);
  endtask

  initial begin
    rst_n = 0; band_valid = 0; gain_we = 0; gain_addr = 0;
    gain_wdata = 0; band0_in = 0; band1_in = 0; band2_in = 0;
    band3_in = 0; band4_in = 0;
    unity();
    repeat (2) @(negedge clk);
    chk("rst_y", $signed(y_out), 0);
    chk("rst_v", 32'(y_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(overrun), 0);
    rst_n = 1;
    @(negedge clk);

    // 1: unity gains, latency and busy length
    set_bands(100, 200, 300, 400, 500);
    start_frame(0, 0, 0);
    chk("t1_model", exp_y, 1500);
    wait_out("t1", 0, 6, 6);

    // 2: single band gain 2.0, ignored address 6
    write_gain(0, 16'h2000);
    for (int i = 1; i < 5; i++) write_gain(3'(i), 16'h0000);
    set_bands(1000, 7777, 7777, 7777, 7777);
    start_frame(0, 0, 0);
    chk("t2_model", exp_y, 2000);
    wait_out("t2a", 0, -1, -1);
    write_gain(6, 16'h7fff);
    start_frame(0, 0, 0);
    wait_out("t2b", 0, -1, -1);

    // 3: saturation both ways
    for (int i = 0; i < 5; i++) write_gain(3'(i), 16'h7fff);
    set_bands(32767, 32767, 32767, 32767, 32767);
    start_frame(0, 0, 0);
    chk("t3_model_hi", exp_y, 32767);
    wait_out("t3hi", 0, -1, -1);
    set_bands(-32768, -32768, -32768, -32768, -32768);
    start_frame(0, 0, 0);
    chk("t3_model_lo", exp_y, -32768);
    wait_out("t3lo", 0, -1, -1);

    // 4: rounding with gain 0.5
    write_gain(0, 16'h0800);
    for (int i = 1; i < 5; i++) write_gain(3'(i), 16'h0000);
    set_bands(1, 0, 0, 0, 0);
    start_frame(0, 0, 0);
    wait_out("t4p1", 0, -1, -1);
    chk("t4p1_const", $signed(y_out), 1);
    set_bands(-1, 0, 0, 0, 0);
    start_frame(0, 0, 0);
    wait_out("t4m1", 0, -1, -1);
    chk("t4m1_const", $signed(y_out), 0);
    set_bands(3, 0, 0, 0, 0);
    start_frame(0, 0, 0);
    wait_out("t4p3", 0, -1, -1);
    chk("t4p3_const", $signed(y_out), 2);

    // write-through: gain write on the accepting edge
    set_bands(100, 0, 0, 0, 0);
    start_frame(1, 0, 16'h3000);
    chk("wt_model", exp_y, 300);
    wait_out("wt", 0, 6, -1);

    // 5: overlap, gain write mid-frame plus ignored band_valid
    for (int i = 0; i < 5; i++) write_gain(3'(i), 16'h1000);
    set_bands(10, 10, 10, 10, 10);
    start_frame(0, 0, 0);
    @(negedge clk);
    gain_we = 1; gain_addr = 0; gain_wdata = 16'h0000;
    band_valid = 1;
    @(negedge clk);
    gain_we = 0; band_valid = 0;
    chk("t5_busy", 32'(busy), 1);
    chk("t5_ovr", 32'(overrun), 1);
    chk("t5_model", exp_y, 50);
    wait_out("t5a", 2, 6, -1);
    gm[0] = 16'h0000;
    start_frame(0, 0, 0);
    chk("t5_model_b", exp_y, 40);
    wait_out("t5b", 0, -1, -1);
    chk("t5_ovr_sticky", 32'(overrun), 1);

    // 6: reset mid-frame
    set_bands(9, 9, 9, 9, 9);
    start_frame(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    unity();
    begin
      int pulses = 0;
      repeat (3) begin
        @(negedge clk);
        if (y_valid) pulses++;
      end
      rst_n = 1;
      repeat (6) begin
        @(negedge clk);
        if (y_valid) pulses++;
      end
      chk("t6_nopulse", pulses, 0);
    end
    chk("t6_y", $signed(y_out), 0);
    chk("t6_ovr", 32'(overrun), 0);
    chk("t6_busy", 32'(busy), 0);
    set_bands(1, 1, 1, 1, 1);
    start_frame(0, 0, 0);
    chk("t6_model", exp_y, 5);
    wait_out("t6", 0, 6, -1);

    // randomized frames with gain traffic between and during frames
    for (int k = 0; k < 30; k++) begin
      int nw = $urandom_range(0, 3);
      int pre;
      for (int j = 0; j < nw; j++)
        write_gain(3'($urandom_range(0, 7)), 16'($urandom));
      for (int i = 0; i < 5; i++) bnd[i] = 16'($urandom);
      if ($urandom_range(0, 3) == 0)
        start_frame(1, 3'($urandom_range(0, 7)), 16'($urandom));
      else
        start_frame(0, 0, 0);
      pre = 0;
      if ($urandom_range(0, 1) == 1) begin
        // mid-frame write lands in shadow only; model already sampled
        write_gain(3'($urandom_range(0, 4)), 16'($urandom));
        pre = 1;
      end
      wait_out($sformatf("rnd%0d", k), pre, 6, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eq_band_mixer.md
Name: eq_band_mixer

Overview:
Downstream recombination stage of the 5-band FIR audio equalizer. It accepts one sample from each of the five band filters (fir_bandpass0..4) per audio frame. It weights each band by a programmable signed gain using a single time-multiplexed multiplier, then sums, rounds and saturates to one 16-bit equalized output sample with a valid strobe. Gains are written through a simple register port and double-buffered, so a sample never mixes old and new gains.

Parameters:
N_BAND, 5, number of bands combined (the FSM and test plan assume 5)
GAIN_FRAC, 12, fractional bits of the gain format (Q3.12 signed; 0x1000 = 1.0)
ACC_W, 35, accumulator width in bits (covers 5 full-scale 32-bit products without overflow)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
band_valid  input  1  one-cycle strobe: all five band inputs hold a new frame
band0_in  input  16  signed band 0 sample
band1_in  input  16  signed band 1 sample
band2_in  input  16  signed band 2 sample
band3_in  input  16  signed band 3 sample
band4_in  input  16  signed band 4 sample
gain_we  input  1  gain write enable
gain_addr  input  3  gain index 0..4; values 5..7 are ignored
gain_wdata  input  16  signed Q3.12 gain value
y_out  output  16  signed mixed output sample
y_valid  output  1  one-cycle strobe: y_out updated
busy  output  1  high while a frame is in progress (state != IDLE)
overrun  output  1  sticky: band_valid arrived while busy

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; y_out=0, y_valid=0, busy=0, overrun=0.
  - Accumulator and latched bands cleared.
  - Shadow and active gains all set to 0x1000 (unity).
  - Reset mid-frame aborts the frame; no y_valid is produced.
- Gain port:
  - On a clock edge with gain_we=1 and gain_addr<5, shadow_gain[gain_addr] <= gain_wdata.
  - Writes to addresses 5..7 have no effect.
  - Writes are accepted in any state.
- FSM states:
  - IDLE: when band_valid=1, latch band0..4_in, copy all shadow gains to active gains, acc<=0, idx<=0, go to MAC. The copy takes the value written on that same edge if gain_we also fires (write-through).
  - MAC: once per cycle, acc <= acc + sext(band[idx] * active_gain[idx]), using one 16x16 signed multiplier with a 32-bit product. idx increments 0..4. After idx==4 is accumulated, go to OUT. This is 5 cycles.
  - OUT:
    - r = (acc + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC (round half up, arithmetic shift).
    - Saturate r to [-32768, 32767] and register it into y_out.
    - y_valid <= 1 for exactly one cycle; go to IDLE.
- Latency:
  - Edge E0 samples band_valid; edges E1..E5 accumulate; edge E6 updates y_out and raises y_valid.
  - y_valid is high between E6 and E7.
  - Minimum frame spacing is 7 cycles. A band_valid accepted on the edge where y_valid falls (E7) is legal.
- y_out holds its value between strobes.
- band_valid while busy (MAC or OUT): the strobe is ignored, overrun <= 1, and the current frame continues unaffected. overrun clears only on reset.
- busy = 1 in MAC and OUT, 0 in IDLE.
- Gain writes during MAC/OUT change only the shadow copy and affect the next frame only.

Test Plan:
1. Reset, default unity gains; bands 100,200,300,400,500 with band_valid -> y_out=1500, y_valid high exactly 6 edges after the accepting edge, for one cycle; busy high 6 cycles.
2. gain0=0x2000, gains1..4=0; band0=1000, others 7777 -> y_out=2000; a write to gain_addr=6 (0x7FFF) is ignored, so a repeat frame still gives 2000.
3. Saturation: all gains 0x7FFF, all bands 0x7FFF -> y_out=32767; all bands 0x8000 -> y_out=-32768.
4. Rounding: gain0=0x0800, others 0; band0=1 -> y_out=1; band0=-1 -> y_out=0; band0=3 -> y_out=2.
5. Overlap: start a frame of bands 10 (unity); at E2 write gain0=0 and pulse band_valid -> output is 50, overrun=1, busy unaffected; the next accepted frame of 10s gives 40.
6. Assert rst_n low at E3 of a frame -> y_valid never pulses, y_out=0, overrun=0, gains return to 0x1000; a following frame of 1,1,1,1,1 gives 5.
